// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the single-port memory arbiter.
package riscv_mem_pkg;

    typedef enum logic [0:0] {
        IDLE,
        BUSY
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } arb_owner_t;

    localparam int unsigned MEM_LAT_MAX = 7;

    function automatic int unsigned lat_cnt_w(input int unsigned lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between IF and D ports.
// ARB_RR_EN: alternate ports on contention instead of fixed D priority.
module mem_arb_pick
    import riscv_mem_pkg::*;
(
    input  logic       if_req_i,
    input  logic       d_req_i,
    input  arb_owner_t last_gnt_i,
    input  logic       issue_window_i,
    output logic       gnt_if_o,
    output logic       gnt_d_o,
    output arb_owner_t sel_o
);

    logic pick_if;

`ifdef ARB_RR_EN
    assign pick_if = if_req_i && (!d_req_i || last_gnt_i == OWN_D);
`else
    logic unused_last_gnt;
    assign unused_last_gnt = ^last_gnt_i;
    assign pick_if = if_req_i && !d_req_i;
`endif

    assign gnt_if_o = issue_window_i && pick_if;
    assign gnt_d_o  = issue_window_i && d_req_i && !pick_if;
    assign sel_o    = pick_if ? OWN_IF : (d_req_i ? OWN_D : OWN_NONE);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between IF and D requesters.
// ARB_RR_EN (optional): round-robin on simultaneous requests.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              IF_REQ,
    input  logic [ADDR_W-1:0] IF_ADDR,
    output logic              IF_GNT,
    output logic              IF_RVALID,
    output logic [DATA_W-1:0] IF_RDATA,
    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    output logic              D_GNT,
    output logic              D_RVALID,
    output logic [DATA_W-1:0] D_RDATA,
    output logic              M_EN,
    output logic              M_WE,
    output logic [ADDR_W-1:0] M_ADDR,
    output logic [DATA_W-1:0] M_WDATA,
    input  logic [DATA_W-1:0] M_RDATA
);

    localparam int unsigned LW = lat_cnt_w(MEM_LAT);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    arb_owner_t        last_gnt_q, last_gnt_d;
    arb_owner_t        sel;
    logic [LW-1:0]     lat_q, lat_d;
    logic              store_q, store_d;
    logic [ADDR_W-1:0] maddr_q;
    logic              resp, issue_window, gnt_if, gnt_d, accept;

    // Gating with RSTN keeps a grant from being offered in a cycle whose edge resets.
    assign resp         = RSTN && (state_q == BUSY) && (lat_q == LW'(1));
    assign issue_window = RSTN && ((state_q == IDLE) || resp);
    assign accept       = gnt_if || gnt_d;

    mem_arb_pick u_pick (
        .if_req_i       (IF_REQ),
        .d_req_i        (D_REQ),
        .last_gnt_i     (last_gnt_q),
        .issue_window_i (issue_window),
        .gnt_if_o       (gnt_if),
        .gnt_d_o        (gnt_d),
        .sel_o          (sel)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lat_d      = lat_q;
        last_gnt_d = last_gnt_q;
        store_d    = store_q;
        if (accept) begin
            state_d    = BUSY;
            owner_d    = sel;
            lat_d      = LW'(MEM_LAT);
            last_gnt_d = sel;
            store_d    = gnt_d && D_WE;
        end else if (resp) begin
            state_d = IDLE;
            owner_d = OWN_NONE;
            lat_d   = '0;
            store_d = 1'b0;
        end else if (state_q == BUSY) begin
            lat_d = lat_q - LW'(1);
        end
    end

    always_comb begin
        IF_GNT    = gnt_if;
        D_GNT     = gnt_d;
        M_EN      = accept;
        M_WE      = gnt_d && D_WE;
        M_ADDR    = gnt_d ? D_ADDR : (gnt_if ? IF_ADDR : maddr_q);
        M_WDATA   = (gnt_d && D_WE) ? D_WDATA : '0;
        IF_RVALID = resp && (owner_q == OWN_IF);
        D_RVALID  = resp && (owner_q == OWN_D);
        IF_RDATA  = IF_RVALID ? M_RDATA : '0;
        D_RDATA   = (D_RVALID && !store_q) ? M_RDATA : '0;
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q    <= IDLE;
            owner_q    <= OWN_NONE;
            lat_q      <= '0;
            last_gnt_q <= OWN_IF;
            store_q    <= 1'b0;
            maddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            lat_q      <= lat_d;
            last_gnt_q <= last_gnt_d;
            store_q    <= store_d;
            maddr_q    <= M_ADDR;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench: instance a with MEM_LAT=1, instance b with MEM_LAT=3.
module tb_mem_port_arbiter;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic CLK = 1'b0;
    logic RSTN;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_total = 0;
    logic mon_en = 1'b0;

    exp_t q_aif[$], q_ad[$], q_bif[$], q_bd[$];

    logic        a_if_req, a_if_gnt, a_if_rvalid, a_d_req, a_d_we, a_d_gnt, a_d_rvalid;
    logic [31:0] a_if_addr, a_if_rdata, a_d_addr, a_d_wdata, a_d_rdata;
    logic        a_m_en, a_m_we;
    logic [31:0] a_m_addr, a_m_wdata, a_m_rdata;
    logic        b_if_req, b_if_gnt, b_if_rvalid, b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
    logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
    logic        b_m_en, b_m_we;
    logic [31:0] b_m_addr, b_m_wdata, b_m_rdata;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_a (
        .CLK(CLK), .RSTN(RSTN),
        .IF_REQ(a_if_req), .IF_ADDR(a_if_addr), .IF_GNT(a_if_gnt),
        .IF_RVALID(a_if_rvalid), .IF_RDATA(a_if_rdata),
        .D_REQ(a_d_req), .D_WE(a_d_we), .D_ADDR(a_d_addr), .D_WDATA(a_d_wdata),
        .D_GNT(a_d_gnt), .D_RVALID(a_d_rvalid), .D_RDATA(a_d_rdata),
        .M_EN(a_m_en), .M_WE(a_m_we), .M_ADDR(a_m_addr), .M_WDATA(a_m_wdata),
        .M_RDATA(a_m_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_b (
        .CLK(CLK), .RSTN(RSTN),
        .IF_REQ(b_if_req), .IF_ADDR(b_if_addr), .IF_GNT(b_if_gnt),
        .IF_RVALID(b_if_rvalid), .IF_RDATA(b_if_rdata),
        .D_REQ(b_d_req), .D_WE(b_d_we), .D_ADDR(b_d_addr), .D_WDATA(b_d_wdata),
        .D_GNT(b_d_gnt), .D_RVALID(b_d_rvalid), .D_RDATA(b_d_rdata),
        .M_EN(b_m_en), .M_WE(b_m_we), .M_ADDR(b_m_addr), .M_WDATA(b_m_wdata),
        .M_RDATA(b_m_rdata)
    );

    function automatic logic [31:0] exp_word(input logic [31:0] addr);
        return 32'hC0DE_0000 | {22'b0, addr[11:2]};
    endfunction

    function automatic exp_t mk(input logic [31:0] data, input int due);
        exp_t e;
        e.data = data;
        e.due  = due;
        return e;
    endfunction

    // Memory models: unwritten words read back as exp_word(addr).
    logic [31:0] mem_a [int];
    logic [31:0] mem_b [int];
    logic [31:0] a_rd;
    logic [31:0] b_pipe [3];

    always @(posedge CLK) begin
        if (a_m_en) begin
            if (a_m_we) mem_a[int'(a_m_addr[11:2])] = a_m_wdata;
            else a_rd <= mem_a.exists(int'(a_m_addr[11:2])) ? mem_a[int'(a_m_addr[11:2])] : exp_word(a_m_addr);
        end
    end
    assign a_m_rdata = a_rd;

    always @(posedge CLK) begin
        if (b_m_en) begin
            if (b_m_we) mem_b[int'(b_m_addr[11:2])] = b_m_wdata;
            else b_pipe[0] <= mem_b.exists(int'(b_m_addr[11:2])) ? mem_b[int'(b_m_addr[11:2])] : exp_word(b_m_addr);
        end
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign b_m_rdata = b_pipe[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_rv(input string tag, input logic rv, input logic [31:0] rd,
                          input logic due, input logic [31:0] exp);
        if (due) begin
            chk({tag, "_rvalid"}, {31'b0, rv}, 32'd1);
            chk({tag, "_rdata"}, rd, exp);
        end else if (rv) begin
            chk({tag, "_unexpected_rvalid"}, {31'b0, rv}, 32'd0);
        end
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            chk_rv("a_if", a_if_rvalid, a_if_rdata, q_aif.size() > 0 && q_aif[0].due == cyc,
                   q_aif.size() > 0 ? q_aif[0].data : 32'd0);
            if (q_aif.size() > 0 && q_aif[0].due == cyc) void'(q_aif.pop_front());
            chk_rv("a_d", a_d_rvalid, a_d_rdata, q_ad.size() > 0 && q_ad[0].due == cyc,
                   q_ad.size() > 0 ? q_ad[0].data : 32'd0);
            if (q_ad.size() > 0 && q_ad[0].due == cyc) void'(q_ad.pop_front());
            chk_rv("b_if", b_if_rvalid, b_if_rdata, q_bif.size() > 0 && q_bif[0].due == cyc,
                   q_bif.size() > 0 ? q_bif[0].data : 32'd0);
            if (q_bif.size() > 0 && q_bif[0].due == cyc) void'(q_bif.pop_front());
            chk_rv("b_d", b_d_rvalid, b_d_rdata, q_bd.size() > 0 && q_bd[0].due == cyc,
                   q_bd.size() > 0 ? q_bd[0].data : 32'd0);
            if (q_bd.size() > 0 && q_bd[0].due == cyc) void'(q_bd.pop_front());
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_d;
        RSTN = 1'b0;
        a_if_req = 0; a_if_addr = '0; a_d_req = 0; a_d_we = 0; a_d_addr = '0; a_d_wdata = '0;
        b_if_req = 0; b_if_addr = '0; b_d_req = 0; b_d_we = 0; b_d_addr = '0; b_d_wdata = '0;

        // Reset values
        tick(); tick();
        smp();
        chk("rst_a_gnt", {30'b0, a_if_gnt, a_d_gnt}, 32'd0);
        chk("rst_a_rvalid", {30'b0, a_if_rvalid, a_d_rvalid}, 32'd0);
        chk("rst_a_men_mwe", {30'b0, a_m_en, a_m_we}, 32'd0);
        chk("rst_a_maddr", a_m_addr, 32'd0);
        chk("rst_a_mwdata", a_m_wdata, 32'd0);
        chk("rst_a_rdata", a_if_rdata | a_d_rdata, 32'd0);
        chk("rst_b_men", {31'b0, b_m_en}, 32'd0);
        tick();
        RSTN = 1'b1;
        mon_en = 1'b1;

        // 1: streaming IF fetches at MEM_LAT=1
        for (int k = 0; k < 3; k++) begin
            if (k != 0) tick();
            a_if_req = 1'b1;
            a_if_addr = 32'(4 * k);
            smp();
            chk("t1_if_gnt", {31'b0, a_if_gnt}, 32'd1);
            chk("t1_m_en", {31'b0, a_m_en}, 32'd1);
            chk("t1_m_addr", a_m_addr, 32'(4 * k));
            chk("t1_m_we", {31'b0, a_m_we}, 32'd0);
            q_aif.push_back(mk(exp_word(32'(4 * k)), cyc + 1));
        end
        tick();
        a_if_req = 1'b0;
        smp();
        chk("t1_idle_m_en", {31'b0, a_m_en}, 32'd0);
        chk("t1_hold_m_addr", a_m_addr, 32'h8);

        // 2: simultaneous IF and D load, D first
        tick();
        a_if_req = 1'b1; a_if_addr = 32'h10;
        a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h400;
        smp();
        chk("t2_d_gnt", {31'b0, a_d_gnt}, 32'd1);
        chk("t2_if_gnt_blocked", {31'b0, a_if_gnt}, 32'd0);
        q_ad.push_back(mk(exp_word(32'h400), cyc + 1));
        tick();
        a_d_req = 1'b0;
        smp();
        chk("t2_if_gnt", {31'b0, a_if_gnt}, 32'd1);
        chk("t2_d_gnt_low", {31'b0, a_d_gnt}, 32'd0);
        q_aif.push_back(mk(exp_word(32'h10), cyc + 1));
        tick();
        a_if_req = 1'b0;

        // 3: store then load to the same address
        a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 32'h404; a_d_wdata = 32'hDEADBEEF;
        smp();
        chk("t3_st_gnt", {31'b0, a_d_gnt}, 32'd1);
        chk("t3_m_we", {31'b0, a_m_we}, 32'd1);
        chk("t3_m_wdata", a_m_wdata, 32'hDEADBEEF);
        q_ad.push_back(mk(32'd0, cyc + 1));
        tick();
        a_d_we = 1'b0; a_d_wdata = '0;
        smp();
        chk("t3_ld_gnt", {31'b0, a_d_gnt}, 32'd1);
        chk("t3_ld_m_we", {31'b0, a_m_we}, 32'd0);
        q_ad.push_back(mk(32'hDEADBEEF, cyc + 1));
        tick();
        a_d_req = 1'b0;
        tick(); tick();

        // 4: back-to-back loads at MEM_LAT=3
        b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h400;
        smp();
        chk("t4_gnt0", {31'b0, b_d_gnt}, 32'd1);
        q_bd.push_back(mk(exp_word(32'h400), cyc + 3));
        tick();
        b_d_addr = 32'h408;
        smp();
        chk("t4_busy1_gnt", {31'b0, b_d_gnt}, 32'd0);
        tick();
        smp();
        chk("t4_busy2_gnt", {31'b0, b_d_gnt}, 32'd0);
        tick();
        smp();
        chk("t4_gnt1", {31'b0, b_d_gnt}, 32'd1);
        q_bd.push_back(mk(exp_word(32'h408), cyc + 3));
        tick();
        b_d_req = 1'b0;
        tick(); tick(); tick();

        // 5: reset one cycle after an accepted load drops it
        b_d_req = 1'b1; b_d_addr = 32'h40C;
        smp();
        chk("t5_gnt", {31'b0, b_d_gnt}, 32'd1);
        tick();
        b_d_req = 1'b0;
        tick();
        RSTN = 1'b0;
        tick();
        RSTN = 1'b1;
        smp();
        chk("t5_gnt_after_rst", {30'b0, b_if_gnt, b_d_gnt}, 32'd0);
        chk("t5_rvalid_after_rst", {30'b0, b_if_rvalid, b_d_rvalid}, 32'd0);
        chk("t5_men_mwe_after_rst", {30'b0, b_m_en, b_m_we}, 32'd0);
        chk("t5_maddr_after_rst", b_m_addr, 32'd0);
        chk("t5_rdata_after_rst", b_d_rdata | b_if_rdata, 32'd0);
        tick(); tick(); tick();
        b_d_req = 1'b1; b_d_addr = 32'h408;
        smp();
        chk("t5_regrant", {31'b0, b_d_gnt}, 32'd1);
        q_bd.push_back(mk(exp_word(32'h408), cyc + 3));
        tick();
        b_d_req = 1'b0;
        tick(); tick(); tick();

        // 6: contention for six issue windows on instance a (last_gnt reset to IF)
        for (int k = 0; k < 6; k++) begin
            if (k != 0) tick();
            a_if_req = 1'b1; a_if_addr = 32'h20;
            a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h400;
`ifdef ARB_RR_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            smp();
            chk("t6_d_gnt", {31'b0, a_d_gnt}, {31'b0, exp_d});
            chk("t6_if_gnt", {31'b0, a_if_gnt}, {31'b0, !exp_d});
            if (exp_d) q_ad.push_back(mk(exp_word(32'h400), cyc + 1));
            else q_aif.push_back(mk(exp_word(32'h20), cyc + 1));
        end
        tick();
        a_if_req = 1'b0; a_d_req = 1'b0;
        repeat (5) tick();
        smp();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
